// File: rtl/alu_operand_loader.sv
// rtl/alu_operand_loader.sv - debounced two-key operand entry stage feeding the ALU under valid/ready
module alu_operand_loader #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [1:0]  key_n,
  input  logic [16:0] sw,
  input  logic        opnd_ready,
  output logic [31:0] port_a,
  output logic [31:0] port_b,
  output logic [3:0]  op,
  output logic        opnd_valid,
  output logic [1:0]  stage
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A  = 2'b00,
    LOAD_B  = 2'b01,
    LOAD_OP = 2'b10,
    VALID   = 2'b11
  } state_t;

  state_t      state;
  logic [1:0]  key_s1, key_s2;
  logic [1:0]  press;
  logic [16:0] sw_s1, sw_s2;
  logic [31:0] sw_ext;

  assign sw_ext = {{16{sw_s2[16]}}, sw_s2[15:0]};
  assign stage  = state;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      key_s1 <= 2'b11;
      key_s2 <= 2'b11;
      sw_s1  <= '0;
      sw_s2  <= '0;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  // Level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples; press fires on the falling flip.
  for (genvar k = 0; k < 2; k++) begin : g_deb
    logic [CW-1:0] cnt;
    logic          level;
    logic          pulse;

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        cnt   <= '0;
        level <= 1'b1;
        pulse <= 1'b0;
      end else begin
        pulse <= 1'b0;
        if (key_s2[k] != level) begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            level <= key_s2[k];
            pulse <= ~key_s2[k];
          end else begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          cnt <= '0;
        end
      end
    end

    assign press[k] = pulse;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= LOAD_A;
      port_a     <= '0;
      port_b     <= '0;
      op         <= '0;
      opnd_valid <= 1'b0;
    end else if (press[1]) begin
      state      <= LOAD_A;
      port_a     <= '0;
      port_b     <= '0;
      op         <= '0;
      opnd_valid <= 1'b0;
    end else begin
      case (state)
        LOAD_A: if (press[0]) begin
          port_a <= sw_ext;
          state  <= LOAD_B;
        end
        LOAD_B: if (press[0]) begin
          port_b <= sw_ext;
          state  <= LOAD_OP;
        end
        LOAD_OP: if (press[0]) begin
          op         <= sw_s2[3:0];
          opnd_valid <= 1'b1;
          state      <= VALID;
        end
        VALID: if (opnd_valid && opnd_ready) begin
          // Operands stay put so the downstream display keeps showing them.
          opnd_valid <= 1'b0;
          state      <= LOAD_A;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule
